// File: rtl/dmem_resp.sv
// Data-memory responder for the MIPS M stage: fixed-latency word RAM with pipeline stall.
// Optional counters are built when DMEM_RESP_STATS_EN is defined (adds stallcnt/misalcnt).
module dmem_resp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memreadm,
  input  logic             memwritem,
  input  logic [WIDTH-1:0] aluoutm,
  input  logic [WIDTH-1:0] writedatam,
  output logic [WIDTH-1:0] readdatam,
  output logic             memstallm,
  output logic             misalignm
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]      stallcnt,
  output logic [15:0]      misalcnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [AW-1:0]    idx_q, in_idx, acc_idx;
  logic [WIDTH-1:0] data_q, acc_data;
  logic             wr_q, acc_wr;
  logic             req, aligned, start, access;
  logic [WIDTH-1:0] mem [DEPTH];

  // Address bits above the RAM index and the byte offset do not select storage.
  logic unused_addr;
  assign unused_addr = ^aluoutm[WIDTH-1:AW+2];

  assign req     = memreadm | memwritem;
  assign aligned = (aluoutm[1:0] == 2'b00);
  assign in_idx  = aluoutm[AW+1:2];
  assign start   = reset && (state == IDLE) && req && aligned;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    memstallm = 1'b0;
    misalignm = 1'b0;
    access    = 1'b0;
    acc_idx   = idx_q;
    acc_data  = data_q;
    acc_wr    = wr_q;
    case (state)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            memstallm = 1'b1;
            if (LATENCY == 1) begin
              // Single-cycle access completes on this edge, straight from the inputs.
              state_nxt = DONE;
              access    = 1'b1;
              acc_idx   = in_idx;
              acc_data  = writedatam;
              acc_wr    = memwritem;
            end else begin
              cnt_nxt   = 4'(LATENCY - 1);
              state_nxt = WAIT;
            end
          end else begin
            misalignm = 1'b1;
          end
        end
      end
      WAIT: begin
        memstallm = 1'b1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      memstallm = 1'b0;
      misalignm = 1'b0;
      access    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      readdatam <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (access && !acc_wr) readdatam <= mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      idx_q  <= in_idx;
      data_q <= writedatam;
      wr_q   <= memwritem;
    end
  end

  // RAM has no reset; a reset during WAIT suppresses the pending write via access.
  always_ff @(posedge clk) begin
    if (access && acc_wr) mem[acc_idx] <= acc_data;
  end

`ifdef DMEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stallcnt <= 32'd0;
      misalcnt <= 16'd0;
    end else begin
      if (memstallm && (stallcnt != 32'hFFFF_FFFF)) stallcnt <= stallcnt + 32'd1;
      if (misalignm && (misalcnt != 16'hFFFF))      misalcnt <= misalcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: LATENCY=2 and LATENCY=1 instances with a load-data scoreboard.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr0, wdat0, addr1, wdat1;
  logic [31:0] rdat0, rdat1;
  logic        stall0, stall1, mis0, mis1;
`ifdef DMEM_RESP_STATS_EN
  logic [31:0] stallcnt0, stallcnt1;
  logic [15:0] misalcnt0, misalcnt1;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expq[$];
  logic [31:0] model0 [256];
  logic [31:0] model1 [256];
  logic [31:0] last0, last1;

  always #5 clk = ~clk;

  dmem_resp #(.WIDTH(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .memreadm(rd0), .memwritem(wr0),
    .aluoutm(addr0), .writedatam(wdat0), .readdatam(rdat0),
    .memstallm(stall0), .misalignm(mis0)
`ifdef DMEM_RESP_STATS_EN
    , .stallcnt(stallcnt0), .misalcnt(misalcnt0)
`endif
  );

  dmem_resp #(.WIDTH(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .memreadm(rd1), .memwritem(wr1),
    .aluoutm(addr1), .writedatam(wdat1), .readdatam(rdat1),
    .memstallm(stall1), .misalignm(mis1)
`ifdef DMEM_RESP_STATS_EN
    , .stallcnt(stallcnt1), .misalcnt(misalcnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit u1, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (u1) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wdat1 = data;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wdat0 = data;
    end
  endtask

  function automatic logic stall_of(input bit u1);
    return u1 ? stall1 : stall0;
  endfunction

  function automatic logic [31:0] rdat_of(input bit u1);
    return u1 ? rdat1 : rdat0;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT in IDLE.
  task automatic access(input bit u1, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data, input string tag);
    int          lat;
    logic [31:0] exp;
    lat = u1 ? 1 : 2;
    drive(u1, rd, wr, addr, data);
    if (wr) begin
      if (u1) model1[addr[9:2]] = data; else model0[addr[9:2]] = data;
    end else if (rd) begin
      expq.push_back(u1 ? model1[addr[9:2]] : model0[addr[9:2]]);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check($sformatf("%s_stall%0d", tag, i), {31'd0, stall_of(u1)}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("%s_stall_done", tag), {31'd0, stall_of(u1)}, 32'd0);
    if (rd && !wr) begin
      exp = expq.pop_front();
      check($sformatf("%s_rdata", tag), rdat_of(u1), exp);
      if (u1) last1 = exp; else last0 = exp;
    end else begin
      check($sformatf("%s_rdata_hold", tag), rdat_of(u1), u1 ? last1 : last0);
    end
    @(posedge clk); #1;
    drive(u1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    last0 = 32'd0;
    last1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
    @(negedge clk);
    check("rst_rdata", rdat0, 32'd0);
    check("rst_stall", {31'd0, stall0}, 32'd0);
    check("rst_misalign", {31'd0, mis0}, 32'd0);
    check("rst_rdata1", rdat1, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;

    // Store then load at 0x10, two-cycle stall each.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "st10");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, "ld10");

    // Misaligned load: flagged, no stall, read data untouched.
    drive(1'b0, 1'b1, 1'b0, 32'h3, 32'd0);
    @(negedge clk);
    check("mis_flag", {31'd0, mis0}, 32'd1);
    check("mis_stall", {31'd0, stall0}, 32'd0);
    check("mis_rdata", rdat0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("mis_after_flag", {31'd0, mis0}, 32'd0);
    check("mis_after_rdata", rdat0, 32'hDEAD_BEEF);
`ifdef DMEM_RESP_STATS_EN
    check("stallcnt", stallcnt0, 32'd4);
    check("misalcnt", {16'd0, misalcnt0}, 32'd1);
`endif
    @(posedge clk); #1;

    // Both strobes high behaves as a store.
    access(1'b0, 1'b1, 1'b1, 32'h44, 32'h0BAD_F00D, "both");
    access(1'b0, 1'b1, 1'b0, 32'h44, 32'd0, "ld44");

    // Address wrap: 0x400 aliases word 0.
    access(1'b0, 1'b0, 1'b1, 32'h400, 32'h0000_1234, "st400");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, "ld0_wrap");

    // Back-to-back loads with no idle gap between requests.
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, "b2b_a");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, "b2b_b");

    // Reset during WAIT drops a pending store.
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, "st20");
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5);
    @(negedge clk);
    check("abort_stall_idle", {31'd0, stall0}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_stall_rst", {31'd0, stall0}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("abort_rdata", rdat0, 32'd0);
    last0 = 32'd0;
    last1 = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, "ld20_after_abort");

    // LATENCY=1 instance: stores then consecutive loads.
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_00A0, "l1_st0");
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'h0000_00B4, "l1_st4");
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0000_00C8, "l1_st8");
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, "l1_ld0");
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, "l1_ld4");
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, "l1_ld8");

    check("scoreboard_empty", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
